// File: rtl/cpu_bus_io_decoder_if.sv
// Z80 bus-side signals and peripheral-side strobes of the IO cycle decoder.
// The CPU/bench drives through master; the decoder uses slave.
interface cpu_bus_io_decoder_if #(
  parameter int N_PORTS = 4
);
  logic [15:0]        a;
  logic [7:0]         d;
  logic               iorq;
  logic               mreq;
  logic               m1;
  logic               rd;
  logic               wr;
  logic               ioreq;
  logic [N_PORTS-1:0] port_hit;
  logic [N_PORTS-1:0] port_rd_stb;
  logic [N_PORTS-1:0] port_wr_stb;
  logic [7:0]         wr_data;
  logic               intack_stb;
  logic               trap_stb;

  modport master (
    output a, d, iorq, mreq, m1, rd, wr,
    input  ioreq, port_hit, port_rd_stb, port_wr_stb, wr_data, intack_stb, trap_stb
  );

  modport slave (
    input  a, d, iorq, mreq, m1, rd, wr,
    output ioreq, port_hit, port_rd_stb, port_wr_stb, wr_data, intack_stb, trap_stb
  );
endinterface

// File: rtl/cpu_bus_io_decoder.sv
// Z80 IO cycle decoder: synchronises the async strobes, classifies IORQ cycles and
// emits one-clock port strobes. Optional M1 trap strobe under `CPU_BUS_M1_TRAP_EN.
module cpu_bus_io_decoder #(
  parameter int                  N_PORTS     = 4,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [16*N_PORTS-1:0] PORT_ADDR = {16'hBFFD, 16'hFFFD, 16'h7FFD, 16'h00FE},
  parameter logic [16*N_PORTS-1:0] PORT_MASK = {16'hC002, 16'hC002, 16'h8002, 16'h0001},
  parameter logic [15:0]         TRAP_ADDR   = 16'h0066
) (
  input  logic                 clk28,
  input  logic                 rst,
  cpu_bus_io_decoder_if.slave  bus
);

`ifdef CPU_BUS_M1_TRAP_EN
  localparam int NSYNC = 5;
`else
  localparam int NSYNC = 4;
`endif

  typedef enum logic [1:0] {IDLE, IO, INTA} state_t;

  logic [NSYNC-1:0]       sync_in;
  logic [NSYNC-1:0]       sync_out;
  logic                   s_iorq, s_m1, s_rd, s_wr;
  logic [SYNC_STAGES-1:0] settle_reg;
  logic                   settle_done;
  logic                   armed_reg, armed_next;
  state_t                 state_reg, state_next;
  logic [N_PORTS-1:0]     hit;
  logic                   ioreq_reg, ioreq_next;
  logic [N_PORTS-1:0]     hit_reg, hit_next;
  logic [N_PORTS-1:0]     rd_stb_reg, rd_stb_next;
  logic [N_PORTS-1:0]     wr_stb_reg, wr_stb_next;
  logic [7:0]             wr_data_reg, wr_data_next;
  logic                   intack_reg, intack_next;

`ifdef CPU_BUS_M1_TRAP_EN
  assign sync_in = {bus.mreq, bus.wr, bus.rd, bus.m1, bus.iorq};
`else
  logic [16:0] unused_cfg;
  assign unused_cfg = {bus.mreq, TRAP_ADDR};
  assign sync_in    = {bus.wr, bus.rd, bus.m1, bus.iorq};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [NSYNC-1:0] stage_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk28) begin
          if (rst) stage_reg <= '1;
          else     stage_reg <= sync_in;
        end
      end else begin : g_next
        always_ff @(posedge clk28) begin
          if (rst) stage_reg <= '1;
          else     stage_reg <= g_sync[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign sync_out = g_sync[SYNC_STAGES-1].stage_reg;
  assign s_iorq   = sync_out[0];
  assign s_m1     = sync_out[1];
  assign s_rd     = sync_out[2];
  assign s_wr     = sync_out[3];

  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_match
      assign hit[gi] = ((bus.a ^ PORT_ADDR[16*gi +: 16]) & PORT_MASK[16*gi +: 16]) == 16'h0000;
    end
  endgenerate

  // The sync chain is preset inactive, so it only reflects the pins once refilled;
  // arming before that would mistake a cycle in progress at reset release for a new one.
  always_ff @(posedge clk28) begin
    if (rst) settle_reg <= '0;
    else     settle_reg <= {settle_reg[SYNC_STAGES-2:0], 1'b1};
  end
  assign settle_done = settle_reg[SYNC_STAGES-1];
  assign armed_next  = armed_reg | (settle_done & s_iorq);

  always_ff @(posedge clk28) begin
    if (rst) begin
      state_reg   <= IDLE;
      armed_reg   <= 1'b0;
      ioreq_reg   <= 1'b0;
      hit_reg     <= '0;
      rd_stb_reg  <= '0;
      wr_stb_reg  <= '0;
      wr_data_reg <= 8'h00;
      intack_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      armed_reg   <= armed_next;
      ioreq_reg   <= ioreq_next;
      hit_reg     <= hit_next;
      rd_stb_reg  <= rd_stb_next;
      wr_stb_reg  <= wr_stb_next;
      wr_data_reg <= wr_data_next;
      intack_reg  <= intack_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ioreq_next   = 1'b0;
    hit_next     = '0;
    rd_stb_next  = '0;
    wr_stb_next  = '0;
    wr_data_next = wr_data_reg;
    intack_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (armed_reg && !s_iorq) begin
          if (!s_m1) begin
            state_next  = INTA;
            intack_next = 1'b1;
          end else if (s_rd ^ s_wr) begin
            state_next = IO;
            ioreq_next = 1'b1;
            hit_next   = hit;
            if (!s_rd) begin
              rd_stb_next = hit;
            end else begin
              wr_stb_next  = hit;
              wr_data_next = bus.d;
            end
          end
        end
      end
      IO: begin
        if (s_iorq) begin
          state_next = IDLE;
        end else begin
          ioreq_next = 1'b1;
          hit_next   = hit_reg;
        end
      end
      INTA: begin
        if (s_iorq) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CPU_BUS_M1_TRAP_EN
  logic s_mreq;
  logic trap_armed_reg, trap_armed_next;
  logic trap_reg, trap_next;

  assign s_mreq = sync_out[4];

  // One pulse per opcode fetch: any M1 memory cycle disarms, M1 going high re-arms.
  always_comb begin
    trap_armed_next = trap_armed_reg;
    trap_next       = 1'b0;
    if (settle_done && s_m1) begin
      trap_armed_next = 1'b1;
    end else if (!s_mreq && !s_m1) begin
      trap_armed_next = 1'b0;
      trap_next       = trap_armed_reg && (bus.a == TRAP_ADDR);
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      trap_armed_reg <= 1'b0;
      trap_reg       <= 1'b0;
    end else begin
      trap_armed_reg <= trap_armed_next;
      trap_reg       <= trap_next;
    end
  end

  assign bus.trap_stb = trap_reg;
`else
  assign bus.trap_stb = 1'b0;
`endif

  assign bus.ioreq       = ioreq_reg;
  assign bus.port_hit    = hit_reg;
  assign bus.port_rd_stb = rd_stb_reg;
  assign bus.port_wr_stb = wr_stb_reg;
  assign bus.wr_data     = wr_data_reg;
  assign bus.intack_stb  = intack_reg;

endmodule
